// File: rtl/alu_result_disp.sv
// Captures the ALU result/flags/opcode on a cap_in edge and shows them on a 4-digit muxed display.
// Optional capture debouncer enabled by defining CAP_DEBOUNCE_EN.
module alu_result_disp #(
  parameter int unsigned SCAN_W = 16,
  parameter int unsigned DB_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap_in,
  input  logic [3:0] res,
  input  logic       car,
  input  logic       of,
  input  logic [2:0] ctrl,
  output logic [7:0] seg_n,
  output logic [3:0] an_n,
  output logic       led_car,
  output logic       led_of,
  output logic       valid
);

  typedef enum logic {StEmpty, StHold} state_t;

  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegDash  = 8'hBF;

  state_t state_q, state_d;

  logic s1, s2, p, cap_lvl, pulse;
  logic [3:0] r_res;
  logic       r_car, r_of;
  logic [2:0] r_ctrl;

  logic [3:0] res_d;
  logic       car_d, of_d;
  logic [2:0] ctrl_d;

  logic [SCAN_W-1:0] cnt_q, cnt_d;
  logic [1:0]        digit_d;
  logic [7:0]        seg_d;
  logic [3:0]        an_d;
  logic [3:0]        mag;

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= cap_in;
      s2 <= s1;
      p  <= cap_lvl;
    end
  end

`ifdef CAP_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt;
  logic            db_lvl;

  // Stable level flips only after s2 disagrees for 2^DB_W consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == {DB_W{1'b1}}) begin
      db_cnt <= '0;
      db_lvl <= s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign cap_lvl = db_lvl;
`else
  logic unused_db_w;
  assign unused_db_w = ^DB_W;
  assign cap_lvl     = s2;
`endif

  assign pulse = cap_lvl & ~p;

  always_comb begin
    state_d = state_q;
    if (pulse) state_d = StHold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      r_res   <= '0;
      r_car   <= 1'b0;
      r_of    <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      state_q <= state_d;
      if (pulse) begin
        r_res  <= res;
        r_car  <= car;
        r_of   <= of;
        r_ctrl <= ctrl;
      end
    end
  end

  // Segment register looks at next-state snapshot so a capture shows on the same edge it loads.
  assign res_d  = pulse ? res  : r_res;
  assign car_d  = pulse ? car  : r_car;
  assign of_d   = pulse ? of   : r_of;
  assign ctrl_d = pulse ? ctrl : r_ctrl;

  assign cnt_d   = cnt_q + 1'b1;
  assign digit_d = cnt_d[SCAN_W-1:SCAN_W-2];
  assign an_d    = ~(4'b0001 << digit_d);
  assign mag     = res_d[3] ? (~res_d + 4'd1) : res_d;

  logic unused_car_d;
  assign unused_car_d = car_d;

  always_comb begin
    seg_d = SegBlank;
    if (state_d == StEmpty) begin
      seg_d = SegDash;
    end else begin
      unique case (digit_d)
        2'd0: begin
          seg_d    = (ctrl_d[2:1] == 2'b00) ? hex_seg(mag) : hex_seg(res_d);
          seg_d[7] = ~of_d;
        end
        2'd1: begin
          if (ctrl_d[2:1] == 2'b00 && res_d[3]) seg_d = SegDash;
        end
        2'd2: seg_d = SegBlank;
        default: seg_d = hex_seg({1'b0, ctrl_d});
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      an_n  <= 4'b1110;
      seg_n <= SegDash;
    end else begin
      cnt_q <= cnt_d;
      an_n  <= an_d;
      seg_n <= seg_d;
    end
  end

  assign led_car = r_car;
  assign led_of  = r_of;
  assign valid   = (state_q == StHold);

endmodule

// File: tb/tb_alu_result_disp.sv
// Directed, table-driven bench for alu_result_disp with SCAN_W=4.
module tb_alu_result_disp;

  logic       clk, rst, cap_in, car, of;
  logic [3:0] res;
  logic [2:0] ctrl;
  logic [7:0] seg_n;
  logic [3:0] an_n;
  logic       led_car, led_of, valid;

  int n_chk  = 0;
  int n_fail = 0;

  alu_result_disp #(.SCAN_W(4), .DB_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .cap_in (cap_in),
    .res    (res),
    .car    (car),
    .of     (of),
    .ctrl   (ctrl),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .led_car(led_car),
    .led_of (led_of),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic       car;
    logic       of;
    logic [2:0] ctrl;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d3;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Waits (bounded) until digit d is lit, sampling on the falling edge.
  task automatic wait_digit(input int d);
    logic [3:0] tgt;
    int t;
    tgt = ~(4'b0001 << d);
    t = 0;
    while (an_n !== tgt && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (an_n !== tgt) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_digit%0d: an_n %b never reached %b", d, an_n, tgt);
    end
  endtask

  task automatic pulse_cap();
    cap_in = 1'b1;
    repeat (3) @(negedge clk);
    cap_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_digits(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d3);
    wait_digit(0); chk({tag, "_d0"}, seg_n, d0);
    wait_digit(1); chk({tag, "_d1"}, seg_n, d1);
    wait_digit(2); chk({tag, "_d2"}, seg_n, 8'hFF);
    wait_digit(3); chk({tag, "_d3"}, seg_n, d3);
  endtask

  initial begin
    vecs[0] = '{4'b1101, 1'b1, 1'b0, 3'd0, 8'hB0, 8'hBF, 8'hC0};
    vecs[1] = '{4'b1000, 1'b0, 1'b1, 3'd1, 8'h00, 8'hBF, 8'hF9};
    vecs[2] = '{4'hA,    1'b0, 1'b0, 3'd5, 8'h88, 8'hFF, 8'h92};
    vecs[3] = '{4'b0111, 1'b1, 1'b1, 3'd0, 8'h78, 8'hFF, 8'hC0};
    vecs[4] = '{4'hF,    1'b0, 1'b0, 3'd7, 8'h8E, 8'hFF, 8'hF8};
    vecs[5] = '{4'h0,    1'b1, 1'b0, 3'd2, 8'hC0, 8'hFF, 8'hA4};
    vecs[6] = '{4'hF,    1'b0, 1'b0, 3'd1, 8'hF9, 8'hBF, 8'hF9};

    rst = 1'b1; cap_in = 1'b0; res = '0; car = 1'b0; of = 1'b0; ctrl = '0;
    #12;
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_an", {4'd0, an_n}, 8'h0E);
    chk("rst_seg", seg_n, 8'hBF);
    @(negedge clk);
    rst = 1'b0;

    // Empty display scan: one digit per 4 cycles, dash everywhere.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << (i / 4));
      chk($sformatf("scan_an%0d", i), {4'd0, an_n}, {4'd0, exp_an});
      chk($sformatf("scan_seg%0d", i), seg_n, 8'hBF);
      @(negedge clk);
    end

    // Capture latency: cap_in rises before edge k, data visible after edge k+2.
    res = 4'h9; car = 1'b1; of = 1'b0; ctrl = 3'd3;
    cap_in = 1'b1;
    @(negedge clk);
    chk("lat_k_valid", {7'd0, valid}, 8'd0);
    @(negedge clk);
    chk("lat_k1_valid", {7'd0, valid}, 8'd0);
    chk("lat_k1_car", {7'd0, led_car}, 8'd0);
    @(negedge clk);
    chk("lat_k2_valid", {7'd0, valid}, 8'd1);
    chk("lat_k2_car", {7'd0, led_car}, 8'd1);
    cap_in = 1'b0;
    repeat (3) @(negedge clk);
    check_digits("lat", 8'h90, 8'hFF, 8'hB0);

    foreach (vecs[i]) begin
      res = vecs[i].res; car = vecs[i].car; of = vecs[i].of; ctrl = vecs[i].ctrl;
      pulse_cap();
      res = ~vecs[i].res; car = ~vecs[i].car; of = ~vecs[i].of;
      chk($sformatf("v%0d_car", i), {7'd0, led_car}, {7'd0, vecs[i].car});
      chk($sformatf("v%0d_of", i), {7'd0, led_of}, {7'd0, vecs[i].of});
      check_digits($sformatf("v%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].d3);
    end

    // Level held high: only the value at the rising edge is captured.
    res = 4'h3; ctrl = 3'd2; of = 1'b0; car = 1'b0;
    cap_in = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 47; i++) begin
      res = 4'(i + 4);
      @(negedge clk);
    end
    check_digits("hold", 8'hB0, 8'hFF, 8'hA4);
    cap_in = 1'b0;
    repeat (4) @(negedge clk);
    check_digits("hold_rel", 8'hB0, 8'hFF, 8'hA4);

    // Asynchronous reset mid-scan, away from any clock edge.
    wait_digit(2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {7'd0, valid}, 8'd0);
    chk("arst_an", {4'd0, an_n}, 8'h0E);
    chk("arst_seg", seg_n, 8'hBF);
    chk("arst_car", {7'd0, led_car}, 8'd0);
    chk("arst_of", {7'd0, led_of}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", {7'd0, valid}, 8'd0);
    chk("post_rst_seg", seg_n, 8'hBF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
